alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 125 ++++++++++++
 tb/tb_alu_seq.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Command / ALU / result bundle for alu_seq. The DUT takes the slave view;
// whatever hosts the command source, the external ALU and the result sink takes the master view.
interface alu_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_acc;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_zero;
  logic       res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, alu_out, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_zero, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, alu_out, res_ready,
    output cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_zero, res_err
  );
endinterface

// File: rtl/alu_seq.sv
// Sequencer that feeds an external combinational ALU and captures its result after EXEC_WAIT cycles.
// Optional accumulator operand enabled by defining ALU_SEQ_ACC_EN.
module alu_seq #(
  parameter int unsigned EXEC_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus,
  output logic [1:0] dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // cmd_ready is high only in IDLE, res_valid only in DONE, and both are flops.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_LD = 4'(EXEC_WAIT);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [2:0] alu_op_q;
  logic [7:0] res_data_q;
  logic       res_zero_q;
  logic       res_err_q;
  logic       ready_q;
  logic       valid_q;

  logic [7:0] a_sel_d;
  logic       capture_d;
  logic       illegal_d;
  logic [7:0] cap_data_d;

  assign capture_d  = (state_q == EXEC) && (cnt_q <= 4'd1);
  assign illegal_d  = (alu_op_q == 3'd7);
  assign cap_data_d = illegal_d ? 8'h00 : bus.alu_out;

`ifdef ALU_SEQ_ACC_EN
  logic [7:0] acc_q;

  assign a_sel_d = bus.cmd_acc ? acc_q : bus.cmd_a;

  // Illegal opcodes leave the running value untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 8'h00;
    end else if (capture_d && !illegal_d) begin
      acc_q <= cap_data_d;
    end
  end
`else
  logic unused_cmd_acc;

  assign unused_cmd_acc = bus.cmd_acc;
  assign a_sel_d        = bus.cmd_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
      alu_op_q   <= 3'd0;
      res_data_q <= 8'h00;
      res_zero_q <= 1'b0;
      res_err_q  <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            alu_a_q  <= a_sel_d;
            alu_b_q  <= bus.cmd_b;
            alu_op_q <= bus.cmd_op;
            cnt_q    <= WAIT_LD;
            state_q  <= EXEC;
            ready_q  <= 1'b0;
          end
        end
        EXEC: begin
          // The counter hits zero on the same edge that captures the ALU output.
          if (capture_d) begin
            cnt_q      <= 4'd0;
            res_data_q <= cap_data_d;
            res_zero_q <= (cap_data_d == 8'h00);
            res_err_q  <= illegal_d;
            state_q    <= DONE;
            valid_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.res_valid = valid_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_err   = res_err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: one instance with EXEC_WAIT=1 under a scoreboard with random traffic,
// and one with EXEC_WAIT=4 for latency and mid-EXEC asynchronous reset.
module tb_alu_seq;

`ifdef ALU_SEQ_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic rst4_n;
  logic [1:0] st1;
  logic [1:0] st4;

  always #5 clk = ~clk;

  alu_seq_if if1 ();
  alu_seq_if if4 ();

  alu_seq #(.EXEC_WAIT(1)) dut  (.clk(clk), .rst_n(rst_n),  .bus(if1), .dbg_state_o(st1));
  alu_seq #(.EXEC_WAIT(4)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(if4), .dbg_state_o(st4));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [9:0] exp_q[$];
  int         lat_q[$];
  logic [7:0] acc_m = 8'h00;
  logic [7:0] hold_a = 8'h00;
  logic [7:0] hold_b = 8'h00;
  logic [2:0] hold_op = 3'd0;
  bit         mon_en = 1'b0;
  bit         rr_rand = 1'b0;
  int         force_low = 0;

  // Result as the specification defines it, in plain arithmetic.
  function automatic logic [7:0] spec_result(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
    int ia = int'(a);
    int ib = int'(b);
    case (op)
      3'd0: return ~a;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return a & b;
      3'd4: return 8'((ia % 16) * (ib % 16));
      3'd5: return 8'((ia + ib) % 256);
      3'd6: return 8'((ia - ib + 256) % 256);
      default: return 8'h00;
    endcase
  endfunction

  // External ALU: emits junk on opcode 7 so the sequencer must force zero itself.
  function automatic logic [7:0] ext_alu(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    return (op == 3'd7) ? 8'hC3 : spec_result(op, a, b);
  endfunction

  assign if1.alu_out = ext_alu(if1.alu_op, if1.alu_a, if1.alu_b);
  assign if4.alu_out = ext_alu(if4.alu_op, if4.alu_a, if4.alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Result consumer
  always @(posedge clk) begin
    #1;
    if (force_low > 0) begin
      if1.res_ready = 1'b0;
      force_low--;
    end else if (rr_rand) begin
      if1.res_ready = ($urandom_range(0, 3) != 0);
    end else begin
      if1.res_ready = 1'b1;
    end
  end

  // Driver: while the DUT is busy, cmd_valid is toggled with junk that must be ignored.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic acc);
    int waited = 0;
    logic [7:0] a_eff;
    logic [7:0] r;
    @(negedge clk);
    while (!if1.cmd_ready && waited < 200) begin
      if1.cmd_valid = 1'($urandom_range(0, 1));
      if1.cmd_op    = 3'($urandom);
      if1.cmd_a     = 8'($urandom);
      if1.cmd_b     = 8'($urandom);
      if1.cmd_acc   = 1'($urandom);
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      checks++;
      failures++;
      $display("FAIL cmd_ready_timeout actual=0 expected=1");
      if1.cmd_valid = 1'b0;
      return;
    end
    if1.cmd_valid = 1'b1;
    if1.cmd_op    = op;
    if1.cmd_a     = a;
    if1.cmd_b     = b;
    if1.cmd_acc   = acc;
    a_eff = (ACC_EN && acc) ? acc_m : a;
    r = spec_result(op, a_eff, b);
    exp_q.push_back({op == 3'd7, r == 8'h00, r});
    lat_q.push_back(cyc + 1 + 1);
    if (ACC_EN && op != 3'd7) acc_m = r;
    @(posedge clk);
    #1;
    if1.cmd_valid = 1'b0;
    hold_a  = a_eff;
    hold_b  = b;
    hold_op = op;
  endtask

  // Monitor
  logic       prev_vld = 1'b0;
  logic       prev_rdy = 1'b0;
  logic [9:0] prev_res = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("alu_a_hold", if1.alu_a, hold_a);
      check("alu_b_hold", if1.alu_b, hold_b);
      check("alu_op_hold", if1.alu_op, hold_op);
      check("ready_valid_excl", if1.cmd_ready & if1.res_valid, 0);
      if (prev_vld && !prev_rdy) begin
        check("res_valid_held", if1.res_valid, 1);
        check("res_stable", {if1.res_err, if1.res_zero, if1.res_data}, prev_res);
        check("cmd_ready_in_done", if1.cmd_ready, 0);
      end
      if (prev_vld && prev_rdy) begin
        check("idle_after_ack", if1.cmd_ready, 1);
        check("valid_drop_after_ack", if1.res_valid, 0);
      end
      if (if1.res_valid && !prev_vld) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          check("result", {if1.res_err, if1.res_zero, if1.res_data}, exp_q.pop_front());
          check("latency_edge", cyc, lat_q.pop_front());
        end
      end
      prev_vld = if1.res_valid;
      prev_rdy = if1.res_ready;
      prev_res = {if1.res_err, if1.res_zero, if1.res_data};
    end
  end

  initial begin
    int w;
    rst_n  = 1'b0;
    rst4_n = 1'b0;
    if1.cmd_valid = 1'b0; if1.cmd_op = 3'd0; if1.cmd_a = 8'h00; if1.cmd_b = 8'h00;
    if1.cmd_acc = 1'b0; if1.res_ready = 1'b1;
    if4.cmd_valid = 1'b0; if4.cmd_op = 3'd0; if4.cmd_a = 8'h00; if4.cmd_b = 8'h00;
    if4.cmd_acc = 1'b0; if4.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_res_valid", if1.res_valid, 0);
    check("rst_res_data", if1.res_data, 0);
    check("rst_flags", {if1.res_zero, if1.res_err}, 0);
    check("rst_alu_regs", {if1.alu_a, if1.alu_b, if1.alu_op}, 0);
    check("rst_state", st1, 0);
    rst_n  = 1'b1;
    rst4_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", if1.cmd_ready, 1);
    check("ready_after_reset4", if4.cmd_ready, 1);
    mon_en = 1'b1;

    // Directed cases
    send(3'd5, 8'h05, 8'h03, 1'b0);
    send(3'd6, 8'h03, 8'h05, 1'b0);
    send(3'd4, 8'hF3, 8'h25, 1'b0);
    send(3'd7, 8'hAA, 8'h55, 1'b0);
    @(negedge clk);
    force_low = 7;
    send(3'd2, 8'hF0, 8'hFF, 1'b0);
    send(3'd5, 8'h10, 8'h01, 1'b0);
    send(3'd5, 8'h40, 8'h02, 1'b1);

    rr_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    rr_rand = 1'b0;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // EXEC_WAIT=4 latency
    if4.cmd_valid = 1'b1; if4.cmd_op = 3'd5; if4.cmd_a = 8'h05; if4.cmd_b = 8'h03;
    @(negedge clk);
    if4.cmd_valid = 1'b0;
    check("w4_no_valid_0", if4.res_valid, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("w4_valid_timing", if4.res_valid, (i == 4) ? 1 : 0);
    end
    check("w4_result", {if4.res_err, if4.res_zero, if4.res_data}, {2'b00, 8'h08});
    @(negedge clk);
    check("w4_idle_again", if4.cmd_ready, 1);

    // Reset in the second EXEC cycle
    if4.cmd_valid = 1'b1; if4.cmd_op = 3'd3; if4.cmd_a = 8'hFF; if4.cmd_b = 8'h3C;
    @(negedge clk);
    if4.cmd_valid = 1'b0;
    check("w4_latched_a", if4.alu_a, 8'hFF);
    @(posedge clk);
    #2 rst4_n = 1'b0;
    #1;
    check("w4_rst_alu_regs", {if4.alu_a, if4.alu_b, if4.alu_op}, 0);
    check("w4_rst_res", {if4.res_err, if4.res_zero, if4.res_data}, 0);
    check("w4_rst_valid", if4.res_valid, 0);
    check("w4_rst_state", st4, 0);
    @(negedge clk);
    rst4_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("w4_post_rst_valid", if4.res_valid, 0);
      check("w4_post_rst_ready", if4.cmd_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
